// File: rtl/ram_dma_pkg.sv
// ram_dma_pkg: shared constants and types for the RAM block-copy/fill initiator.
//   WRITE_ENABLE / WRITE_DISABLE : RAM write-enable levels
//   ZERO_WORD                    : idle value for address/data buses
//   DMA_COPY / DMA_FILL          : transfer mode encodings
//   dma_state_e                  : 2-bit FSM state encoding
package ram_dma_pkg;

  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

  localparam logic DMA_COPY = 1'b0;
  localparam logic DMA_FILL = 1'b1;

  typedef enum logic [1:0] {
    DMA_IDLE = 2'b00,
    DMA_RUN  = 2'b01,
    DMA_DONE = 2'b10,
    DMA_ERR  = 2'b11
  } dma_state_e;

  // Word-address step; wraps modulo 2^32 by construction.
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/ram_dma.sv
// ram_dma: RAM-port initiator performing word-block copy (RAM to RAM) or
// constant fill, one word per cycle, under a start/busy/done handshake.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   start_i, mode_i   : request strobe and mode (0 copy, 1 fill), sampled when idle
//   src_addr_i        : copy source byte address
//   dst_addr_i        : destination byte address
//   len_i             : transfer length in words (0..256)
//   fill_data_i       : fill pattern
//   busy_o            : transfer in progress
//   done_o, err_o     : one-cycle completion / rejection pulses
//   mem_we_o, mem_waddr_o, mem_wdata_o : registered RAM write port
//   mem_raddr_o, mem_rdata_i           : RAM read port (combinational read)
//
// state    | meaning
// ---------+------------------------------------------------------------
// DMA_IDLE | waiting for start_i
// DMA_RUN  | transfer active; rem_q words still to be written
// DMA_DONE | done_o pulse cycle; a new start is accepted here
// DMA_ERR  | err_o pulse cycle; a new start is accepted here
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int LEN_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      fill_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_waddr_o,
  output logic [31:0]      mem_wdata_o,
  output logic [31:0]      mem_raddr_o,
  input  logic [31:0]      mem_rdata_i
);

  dma_state_e       state_q, state_d;
  logic             mode_q, mode_d;
  logic [31:0]      fill_q, fill_d;
  logic [31:0]      wptr_q, wptr_d;
  logic [LEN_W-1:0] rem_q, rem_d;

  logic             busy_d, done_d, err_d, we_d;
  logic [31:0]      waddr_d, wdata_d, raddr_d;

  logic             accept;
  logic             bad_align;
  logic             zero_len;

  assign accept    = (state_q != DMA_RUN) && start_i;
  assign bad_align = ((mode_i == DMA_COPY) && (src_addr_i[1:0] != 2'b00)) ||
                     (dst_addr_i[1:0] != 2'b00);
  assign zero_len  = (len_i == '0);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= DMA_IDLE;
      mode_q      <= DMA_COPY;
      fill_q      <= ZERO_WORD;
      wptr_q      <= ZERO_WORD;
      rem_q       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      mem_we_o    <= WRITE_DISABLE;
      mem_waddr_o <= ZERO_WORD;
      mem_wdata_o <= ZERO_WORD;
      mem_raddr_o <= ZERO_WORD;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      fill_q      <= fill_d;
      wptr_q      <= wptr_d;
      rem_q       <= rem_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      err_o       <= err_d;
      mem_we_o    <= we_d;
      mem_waddr_o <= waddr_d;
      mem_wdata_o <= wdata_d;
      mem_raddr_o <= raddr_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = DMA_IDLE;
    if (state_q == DMA_RUN) begin
      state_d = (rem_q == '0) ? DMA_DONE : DMA_RUN;
    end else if (accept) begin
      if (bad_align)     state_d = DMA_ERR;
      else if (zero_len) state_d = DMA_DONE;
      else               state_d = DMA_RUN;
    end
  end

  // Next values of outputs and datapath registers.
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    we_d    = WRITE_DISABLE;
    waddr_d = mem_waddr_o;
    wdata_d = mem_wdata_o;
    raddr_d = mem_raddr_o;
    mode_d  = mode_q;
    fill_d  = fill_q;
    wptr_d  = wptr_q;
    rem_d   = rem_q;
    if (state_q == DMA_RUN) begin
      if (rem_q != '0) begin
        busy_d  = 1'b1;
        we_d    = WRITE_ENABLE;
        waddr_d = wptr_q;
        wdata_d = (mode_q == DMA_FILL) ? fill_q : mem_rdata_i;
        wptr_d  = next_word(wptr_q);
        rem_d   = rem_q - LEN_W'(1);
        // The read pointer runs one word ahead of the write; stop it on the last word.
        if ((mode_q == DMA_COPY) && (rem_q > LEN_W'(1))) raddr_d = next_word(mem_raddr_o);
      end else begin
        done_d  = 1'b1;
        raddr_d = ZERO_WORD;
      end
    end else if (accept) begin
      if (bad_align) begin
        err_d = 1'b1;
      end else if (zero_len) begin
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
        mode_d = mode_i;
        fill_d = fill_data_i;
        if (mode_i == DMA_COPY) begin
          // First read issues now; writes trail by one cycle.
          raddr_d = src_addr_i;
          wptr_d  = dst_addr_i;
          rem_d   = len_i;
        end else begin
          // Fill needs no read, so the first write issues immediately.
          raddr_d = ZERO_WORD;
          we_d    = WRITE_ENABLE;
          waddr_d = dst_addr_i;
          wdata_d = fill_data_i;
          wptr_d  = next_word(dst_addr_i);
          rem_d   = len_i - LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_dma.sv
module tb_ram_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        mode_i;
  logic [31:0] src_addr_i;
  logic [31:0] dst_addr_i;
  logic [8:0]  len_i;
  logic [31:0] fill_data_i;
  logic        busy_o, done_o, err_o, mem_we_o;
  logic [31:0] mem_waddr_o, mem_wdata_o, mem_raddr_o, mem_rdata_i;

  always #5 clk = ~clk;

  ram_dma #(.LEN_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .fill_data_i(fill_data_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
    .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i)
  );

  // Responder RAM: 256 words, combinational read, write at clock edge.
  logic [31:0] ram [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'h0;
  logic [31:0] pl_data = 32'h0;

  assign mem_rdata_i = ram[mem_raddr_o[9:2]];

  always @(posedge clk) begin
    if (mem_we_o) ram[mem_waddr_o[9:2]] <= mem_wdata_o;
    if (pl_en)    ram[pl_idx] <= pl_data;
  end

  int checks = 0;
  int failures = 0;

  localparam logic [1:0] K_WR = 2'd0, K_DONE = 2'd1, K_ERR = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk_prev;
    logic        prev_val;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_w(input logic [31:0] a, input logic [31:0] d, input logic tight);
    exp_q.push_back('{kind: K_WR, addr: a, data: d, chk_prev: tight, prev_val: 1'b1});
  endtask

  task automatic push_done(input logic after_write);
    exp_q.push_back('{kind: K_DONE, addr: 32'h0, data: 32'h0, chk_prev: 1'b1, prev_val: after_write});
  endtask

  task automatic push_err();
    exp_q.push_back('{kind: K_ERR, addr: 32'h0, data: 32'h0, chk_prev: 1'b1, prev_val: 1'b0});
  endtask

  // Monitor: pops one expectation for each write, done or err event.
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] k;
    if (mem_we_o || done_o || err_o) begin
      k = mem_we_o ? K_WR : (done_o ? K_DONE : K_ERR);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event kind=%0d addr=%h data=%h expected=none", k, mem_waddr_o, mem_wdata_o);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != k) begin
          failures++;
          $display("FAIL event_kind actual=%0d expected=%0d", k, e.kind);
        end else if (k == K_WR && (mem_waddr_o !== e.addr || mem_wdata_o !== e.data)) begin
          failures++;
          $display("FAIL write actual=%h:%h expected=%h:%h", mem_waddr_o, mem_wdata_o, e.addr, e.data);
        end else if (e.chk_prev && (prev_we !== e.prev_val)) begin
          failures++;
          $display("FAIL event_timing kind=%0d prev_we actual=%b expected=%b", k, prev_we, e.prev_val);
        end
      end
    end
    prev_we = mem_we_o;
  end

  task automatic poke(input int idx, input logic [31:0] d);
    pl_en = 1'b1; pl_idx = idx[7:0]; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Drives a one-cycle start; returns at the negedge after the sampling edge.
  task automatic start_xfer(input logic m, input logic [31:0] s, input logic [31:0] d,
                            input logic [8:0] l, input logic [31:0] f);
    mode_i = m; src_addr_i = s; dst_addr_i = d; len_i = l; fill_data_i = f; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    mode_i = ~m; src_addr_i = 32'h1357_9BDF; dst_addr_i = 32'h2468_ACE1; len_i = 9'h1FF;
    fill_data_i = 32'hBAD0_BAD0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_idle_busy"}, {31'h0, busy_o}, 32'h0);
  endtask

  int raddr_bad;

  initial begin
    rst_n = 1'b0; start_i = 1'b0; mode_i = 1'b0; src_addr_i = 32'h0; dst_addr_i = 32'h0;
    len_i = 9'h0; fill_data_i = 32'h0;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_done", {31'h0, done_o}, 32'h0);
    check("rst_err", {31'h0, err_o}, 32'h0);
    check("rst_we", {31'h0, mem_we_o}, 32'h0);
    check("rst_waddr", mem_waddr_o, 32'h0);
    check("rst_wdata", mem_wdata_o, 32'h0);
    check("rst_raddr", mem_raddr_o, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Copy 4 words 0x00 -> 0x40.
    poke(0, 32'hA000_0000); poke(1, 32'hA000_0001); poke(2, 32'hA000_0002); poke(3, 32'hA000_0003);
    push_w(32'h40, 32'hA000_0000, 1'b0); push_w(32'h44, 32'hA000_0001, 1'b1);
    push_w(32'h48, 32'hA000_0002, 1'b1); push_w(32'h4C, 32'hA000_0003, 1'b1);
    push_done(1'b1);
    start_xfer(1'b0, 32'h0, 32'h40, 9'd4, 32'h0);
    check("copy_first_busy", {31'h0, busy_o}, 32'h1);
    check("copy_first_we", {31'h0, mem_we_o}, 32'h0);
    check("copy_first_raddr", mem_raddr_o, 32'h0);
    wait_drain("copy");
    check("copy_ram16", ram[16], 32'hA000_0000);
    check("copy_ram17", ram[17], 32'hA000_0001);
    check("copy_ram18", ram[18], 32'hA000_0002);
    check("copy_ram19", ram[19], 32'hA000_0003);

    // Fill 3 words at 0x100; read address must stay zero.
    push_w(32'h100, 32'hDEAD_BEEF, 1'b0); push_w(32'h104, 32'hDEAD_BEEF, 1'b1);
    push_w(32'h108, 32'hDEAD_BEEF, 1'b1); push_done(1'b1);
    start_xfer(1'b1, 32'h0000_0010, 32'h100, 9'd3, 32'hDEAD_BEEF);
    check("fill_first_we", {31'h0, mem_we_o}, 32'h1);
    raddr_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy_o && mem_raddr_o != 32'h0) raddr_bad++;
      @(negedge clk);
    end
    check("fill_raddr_zero", raddr_bad, 0);
    wait_drain("fill");

    // Zero length: done in the cycle after start, no writes.
    push_done(1'b0);
    start_xfer(1'b0, 32'h0, 32'h80, 9'd0, 32'h0);
    check("len0_done", {31'h0, done_o}, 32'h1);
    check("len0_busy", {31'h0, busy_o}, 32'h0);
    wait_drain("len0");

    // Full-depth fill of 256 words.
    for (int i = 0; i < 256; i++) push_w(32'(i * 4), 32'h1234_5678, (i != 0));
    push_done(1'b1);
    start_xfer(1'b1, 32'h0, 32'h0, 9'h100, 32'h1234_5678);
    wait_drain("fill256");
    check("fill256_ram0", ram[0], 32'h1234_5678);
    check("fill256_ram255", ram[255], 32'h1234_5678);

    // Destination address wraps past 2^32.
    push_w(32'hFFFF_FFFC, 32'hCAFE_0001, 1'b0); push_w(32'h0000_0000, 32'hCAFE_0001, 1'b1);
    push_done(1'b1);
    start_xfer(1'b1, 32'h0, 32'hFFFF_FFFC, 9'd2, 32'hCAFE_0001);
    wait_drain("wrap");
    check("wrap_ram255", ram[255], 32'hCAFE_0001);

    // Misaligned requests are rejected.
    push_err();
    start_xfer(1'b0, 32'h2, 32'h80, 9'd2, 32'h0);
    check("err_src_pulse", {31'h0, err_o}, 32'h1);
    check("err_src_busy", {31'h0, busy_o}, 32'h0);
    wait_drain("err_src");
    push_err();
    start_xfer(1'b1, 32'h0, 32'h81, 9'd2, 32'h0);
    check("err_dst_pulse", {31'h0, err_o}, 32'h1);
    wait_drain("err_dst");
    // Source alignment is irrelevant in fill mode.
    push_w(32'h80, 32'h0000_00F1, 1'b0); push_done(1'b1);
    start_xfer(1'b1, 32'h3, 32'h80, 9'd1, 32'h0000_00F1);
    wait_drain("fill_src_odd");

    // Start pulsed mid-transfer is ignored.
    poke(0, 32'hB000_0000); poke(1, 32'hB000_0001); poke(2, 32'hB000_0002); poke(3, 32'hB000_0003);
    push_w(32'h60, 32'hB000_0000, 1'b0); push_w(32'h64, 32'hB000_0001, 1'b1);
    push_w(32'h68, 32'hB000_0002, 1'b1); push_w(32'h6C, 32'hB000_0003, 1'b1);
    push_done(1'b1);
    start_xfer(1'b0, 32'h0, 32'h60, 9'd4, 32'h0);
    @(negedge clk);
    start_xfer(1'b1, 32'h0, 32'h0, 9'd5, 32'hFFFF_0000);
    wait_drain("ignore_start");
    check("ignore_ram0", ram[0], 32'hB000_0000);

    // Overlapping forward copy by one word.
    poke(0, 32'd1); poke(1, 32'd2); poke(2, 32'd3); poke(3, 32'd4);
    push_w(32'h4, 32'd1, 1'b0); push_w(32'h8, 32'd2, 1'b1); push_w(32'hC, 32'd3, 1'b1);
    push_done(1'b1);
    start_xfer(1'b0, 32'h0, 32'h4, 9'd3, 32'h0);
    wait_drain("overlap");
    check("overlap_ram0", ram[0], 32'd1);
    check("overlap_ram1", ram[1], 32'd1);
    check("overlap_ram2", ram[2], 32'd2);
    check("overlap_ram3", ram[3], 32'd3);

    // Reset after two writes of an 8-word fill.
    poke(128, 32'h0); poke(129, 32'h0); poke(130, 32'h0); poke(131, 32'h0);
    push_w(32'h200, 32'h55, 1'b0); push_w(32'h204, 32'h55, 1'b1);
    start_xfer(1'b1, 32'h0, 32'h200, 9'd8, 32'h55);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_we", {31'h0, mem_we_o}, 32'h0);
    check("rstmid_busy", {31'h0, busy_o}, 32'h0);
    rst_n = 1'b1;
    wait_drain("rstmid");
    check("rstmid_ram128", ram[128], 32'h55);
    check("rstmid_ram129", ram[129], 32'h55);
    check("rstmid_ram130", ram[130], 32'h0);
    check("rstmid_ram131", ram[131], 32'h0);

    // Normal transfer after the aborted one.
    push_w(32'h300, 32'd1, 1'b0); push_w(32'h304, 32'd1, 1'b1); push_done(1'b1);
    start_xfer(1'b0, 32'h0, 32'h300, 9'd2, 32'h0);
    wait_drain("post_rst");
    check("post_rst_ram192", ram[192], 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
